// File: rtl/run_monitor.sv
// run_monitor: per-channel event counters plus a run-cycle watchdog that
// declare DONE or TIMEOUT and pulse finish_req on entry to either.
module run_monitor #(
    parameter int          CHANNELS = 4,
    parameter int          WIDTH    = 32,
    parameter int unsigned TERMINAL = 3,
    parameter int unsigned TIMEOUT  = 100
) (
    input  logic                      clk,
    input  logic                      reset_l,
    input  logic                      start,
    input  logic                      stop,
    input  logic [CHANNELS-1:0]       ch_event,
    output logic [CHANNELS*WIDTH-1:0] count_o,
    output logic [WIDTH-1:0]          cycles_o,
    output logic [1:0]                state_o,
    output logic                      done,
    output logic                      timeout,
    output logic                      finish_req
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TMO} state_t;

    localparam logic [WIDTH-1:0] TERM_W = WIDTH'(TERMINAL);
    localparam logic [WIDTH-1:0] TMO_W  = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] MAX    = '1;
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    state_t                             state, state_nx;
    logic [CHANNELS-1:0][WIDTH-1:0]     cnt;
    logic [WIDTH-1:0]                   cycles;
    logic                               all_done, clear, advance;

    always_comb begin
        all_done = 1'b1;
        for (int i = 0; i < CHANNELS; i++) all_done = all_done && (cnt[i] >= TERM_W);
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state      <= S_IDLE;
            finish_req <= 1'b0;
        end else begin
            state      <= state_nx;
            finish_req <= (state == S_RUN) && (state_nx == S_DONE || state_nx == S_TMO);
        end
    end

    // Completion outranks the watchdog, which outranks an abandon request.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = start ? S_RUN : S_IDLE;
            S_RUN:   state_nx = all_done ? S_DONE : (cycles >= TMO_W) ? S_TMO : stop ? S_IDLE : S_RUN;
            default: state_nx = start ? S_RUN : stop ? S_IDLE : state;
        endcase
    end

    always_comb begin
        state_o = state;
        done    = state == S_DONE;
        timeout = state == S_TMO;
    end

    assign clear   = (state != S_RUN) && start;
    assign advance = (state == S_RUN) && (state_nx == S_RUN);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cycles <= '0;
            cnt    <= '0;
        end else if (clear) begin
            cycles <= '0;
            cnt    <= '0;
        end else if (advance) begin
            cycles <= (cycles == MAX) ? cycles : cycles + ONE;
            for (int i = 0; i < CHANNELS; i++)
                cnt[i] <= (ch_event[i] && cnt[i] != MAX) ? cnt[i] + ONE : cnt[i];
        end
    end

    assign count_o  = cnt;
    assign cycles_o = cycles;

    a_excl: assert property (@(posedge clk) disable iff (!reset_l) !(done && timeout));
    a_pulse: assert property (@(posedge clk) disable iff (!reset_l) finish_req |=> !finish_req);
    a_frozen: assert property (@(posedge clk) disable iff (!reset_l)
        (state != S_RUN && !start) |=> ($stable(count_o) && $stable(cycles_o)));
    c_done: cover property (@(posedge clk) disable iff (!reset_l) state == S_DONE);
    c_tmo: cover property (@(posedge clk) disable iff (!reset_l) state == S_TMO);
endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed scenarios on three parameterisations plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_run_monitor;
    logic clk = 1'b0;
    logic reset_l = 1'b0;
    always #5 clk = ~clk;

    logic         a_start = 0, a_stop = 0;
    logic [3:0]   a_ev = '0;
    logic [127:0] a_count;
    logic [31:0]  a_cycles;
    logic [1:0]   a_state;
    logic         a_done, a_timeout, a_fin;

    logic         b_start = 0, b_stop = 0;
    logic [3:0]   b_ev = '0;
    logic [127:0] b_count;
    logic [31:0]  b_cycles;
    logic [1:0]   b_state;
    logic         b_done, b_timeout, b_fin;

    logic         c_start = 0, c_stop = 0;
    logic [1:0]   c_ev = '0;
    logic [7:0]   c_count;
    logic [3:0]   c_cycles;
    logic [1:0]   c_state;
    logic         c_done, c_timeout, c_fin;

    int errors = 0;
    int checks = 0;

    run_monitor #(.CHANNELS(4), .WIDTH(32), .TERMINAL(3), .TIMEOUT(100)) dut_a (
        .clk(clk), .reset_l(reset_l), .start(a_start), .stop(a_stop), .ch_event(a_ev),
        .count_o(a_count), .cycles_o(a_cycles), .state_o(a_state), .done(a_done),
        .timeout(a_timeout), .finish_req(a_fin));

    run_monitor #(.CHANNELS(4), .WIDTH(32), .TERMINAL(3), .TIMEOUT(4)) dut_b (
        .clk(clk), .reset_l(reset_l), .start(b_start), .stop(b_stop), .ch_event(b_ev),
        .count_o(b_count), .cycles_o(b_cycles), .state_o(b_state), .done(b_done),
        .timeout(b_timeout), .finish_req(b_fin));

    run_monitor #(.CHANNELS(2), .WIDTH(4), .TERMINAL(3), .TIMEOUT(15)) dut_c (
        .clk(clk), .reset_l(reset_l), .start(c_start), .stop(c_stop), .ch_event(c_ev),
        .count_o(c_count), .cycles_o(c_cycles), .state_o(c_state), .done(c_done),
        .timeout(c_timeout), .finish_req(c_fin));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        tick();
        checks++; if (a_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", a_state); end
        checks++; if (a_count !== '0 || a_cycles !== '0) begin errors++; $display("FAIL reset_counters count=%0h cycles=%0d exp=0", a_count, a_cycles); end
        checks++; if ({a_done, a_timeout, a_fin} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {a_done, a_timeout, a_fin}); end
        reset_l = 1'b1;
        tick();
        checks++; if (a_state !== 2'd0) begin errors++; $display("FAIL reset_idle_hold got=%0d exp=0", a_state); end
    endtask

    task automatic test_nominal();
        a_start = 1;
        tick();
        checks++; if (a_state !== 2'd1 || a_cycles !== 32'd0) begin errors++; $display("FAIL nominal_e0 state=%0d cycles=%0d exp=1,0", a_state, a_cycles); end
        a_start = 0;
        a_ev = 4'hf;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (a_count !== {4{32'(k)}} || a_cycles !== 32'(k)) begin errors++; $display("FAIL nominal_count_e%0d got=%0h cycles=%0d exp=%0d", k, a_count, a_cycles, k); end
        end
        tick();
        checks++; if (a_state !== 2'd2 || a_done !== 1'b1 || a_fin !== 1'b1) begin errors++; $display("FAIL nominal_e4 state=%0d done=%b fin=%b exp=2,1,1", a_state, a_done, a_fin); end
        tick();
        checks++; if (a_fin !== 1'b0 || a_done !== 1'b1) begin errors++; $display("FAIL nominal_e5 fin=%b done=%b exp=0,1", a_fin, a_done); end
        checks++; if (a_count !== {4{32'd3}}) begin errors++; $display("FAIL nominal_frozen got=%0h exp=3 each", a_count); end
        a_ev = '0;
    endtask

    task automatic test_timeout();
        int pulses = 0;
        a_start = 1;
        a_ev = 4'b0111;
        tick();
        checks++; if (a_state !== 2'd1 || a_count !== '0 || a_cycles !== '0) begin errors++; $display("FAIL tmo_restart state=%0d count=%0h cycles=%0d exp=1,0,0", a_state, a_count, a_cycles); end
        a_start = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            pulses += int'(a_fin);
        end
        checks++; if (a_state !== 2'd1 || a_cycles !== 32'd100) begin errors++; $display("FAIL tmo_e100 state=%0d cycles=%0d exp=1,100", a_state, a_cycles); end
        tick();
        pulses += int'(a_fin);
        checks++; if (a_state !== 2'd3 || a_timeout !== 1'b1 || a_fin !== 1'b1 || a_done !== 1'b0) begin errors++; $display("FAIL tmo_e101 state=%0d timeout=%b fin=%b done=%b exp=3,1,1,0", a_state, a_timeout, a_fin, a_done); end
        for (int k = 0; k < 4; k++) begin
            tick();
            pulses += int'(a_fin);
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL tmo_pulses got=%0d exp=1", pulses); end
        checks++; if (a_cycles !== 32'd100 || a_count !== {32'd0, {3{32'd100}}}) begin errors++; $display("FAIL tmo_frozen cycles=%0d count=%0h exp=100, ch3=0", a_cycles, a_count); end
        a_ev = '0;
    endtask

    task automatic test_stop_restart();
        a_start = 1;
        a_ev = 4'hf;
        tick();
        a_start = 0;
        tick();
        tick();
        checks++; if (a_count !== {4{32'd2}}) begin errors++; $display("FAIL stop_pre got=%0h exp=2 each", a_count); end
        a_stop = 1;
        tick();
        checks++; if (a_state !== 2'd0 || a_count !== {4{32'd2}} || a_cycles !== 32'd2) begin errors++; $display("FAIL stop_idle state=%0d count=%0h cycles=%0d exp=0,2,2", a_state, a_count, a_cycles); end
        tick();
        checks++; if (a_state !== 2'd0 || a_count !== {4{32'd2}}) begin errors++; $display("FAIL stop_in_idle state=%0d count=%0h exp=0,2", a_state, a_count); end
        a_start = 1;
        tick();
        checks++; if (a_state !== 2'd1 || a_count !== '0 || a_cycles !== '0) begin errors++; $display("FAIL start_and_stop state=%0d count=%0h cycles=%0d exp=1,0,0", a_state, a_count, a_cycles); end
        a_start = 0;
        a_stop = 0;
        a_ev = '0;
    endtask

    task automatic test_mid_reset();
        a_ev = 4'b0001;
        for (int k = 0; k < 50; k++) tick();
        checks++; if (a_cycles !== 32'd50 || a_state !== 2'd1) begin errors++; $display("FAIL midrst_pre cycles=%0d state=%0d exp=50,1", a_cycles, a_state); end
        #2 reset_l = 1'b0;
        #1;
        checks++; if (a_state !== 2'd0 || a_count !== '0 || a_cycles !== '0 || {a_done, a_timeout, a_fin} !== 3'b000) begin errors++; $display("FAIL midrst_async state=%0d count=%0h cycles=%0d flags=%b exp=all 0", a_state, a_count, a_cycles, {a_done, a_timeout, a_fin}); end
        @(negedge clk);
        reset_l = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        checks++; if (a_state !== 2'd0 || a_cycles !== '0 || a_count !== '0) begin errors++; $display("FAIL midrst_after state=%0d cycles=%0d count=%0h exp=0,0,0", a_state, a_cycles, a_count); end
        a_ev = '0;
    endtask

    task automatic test_simultaneous();
        int tmo_seen = 0;
        b_start = 1;
        tick();
        b_start = 0;
        b_ev = 4'b0111;
        tick();
        b_ev = 4'hf;
        tick();
        tick();
        checks++; if (b_state !== 2'd1 || b_cycles !== 32'd3 || b_count[127:96] !== 32'd2) begin errors++; $display("FAIL simul_e3 state=%0d cycles=%0d ch3=%0d exp=1,3,2", b_state, b_cycles, b_count[127:96]); end
        tick();
        tmo_seen += int'(b_timeout);
        checks++; if (b_state !== 2'd1 || b_cycles !== 32'd4 || b_count[127:96] !== 32'd3) begin errors++; $display("FAIL simul_e4 state=%0d cycles=%0d ch3=%0d exp=1,4,3", b_state, b_cycles, b_count[127:96]); end
        b_ev = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            tmo_seen += int'(b_timeout);
            if (k == 0) begin
                checks++; if (b_state !== 2'd2 || b_done !== 1'b1 || b_fin !== 1'b1) begin errors++; $display("FAIL simul_e5 state=%0d done=%b fin=%b exp=2,1,1", b_state, b_done, b_fin); end
            end
        end
        checks++; if (tmo_seen != 0) begin errors++; $display("FAIL simul_timeout got=%0d cycles high exp=0", tmo_seen); end
    endtask

    task automatic test_saturation();
        c_start = 1;
        tick();
        c_start = 0;
        c_ev = 2'b01;
        for (int k = 0; k < 15; k++) tick();
        checks++; if (c_state !== 2'd1 || c_cycles !== 4'd15 || c_count !== 8'h0f) begin errors++; $display("FAIL sat_e15 state=%0d cycles=%0d count=%0h exp=1,15,0f", c_state, c_cycles, c_count); end
        tick();
        checks++; if (c_state !== 2'd3 || c_timeout !== 1'b1 || c_fin !== 1'b1) begin errors++; $display("FAIL sat_e16 state=%0d timeout=%b fin=%b exp=3,1,1", c_state, c_timeout, c_fin); end
        tick();
        tick();
        checks++; if (c_count !== 8'h0f || c_cycles !== 4'd15) begin errors++; $display("FAIL sat_frozen count=%0h cycles=%0d exp=0f,15", c_count, c_cycles); end
        c_ev = '0;
    endtask

    task automatic test_random();
        int st;
        longint mc[4];
        longint cy;
        bit mf, all;
        logic [127:0] exp_cnt;
        reset_l = 1'b0;
        tick();
        reset_l = 1'b1;
        st = 0;
        cy = 0;
        mc = '{default: 0};
        for (int n = 0; n < 1500; n++) begin
            int p;
            bit sparse;
            sparse = ((n / 300) % 2) == 1;
            p = sparse ? 40 : 3;
            a_start = $urandom_range(0, 19) == 0;
            a_stop = $urandom_range(0, sparse ? 199 : 29) == 0;
            for (int i = 0; i < 4; i++) a_ev[i] = $urandom_range(0, p - 1) == 0;
            tick();
            all = 1;
            for (int i = 0; i < 4; i++) if (mc[i] < 3) all = 0;
            mf = 0;
            if (st == 1) begin
                if (all) begin st = 2; mf = 1; end
                else if (cy >= 100) begin st = 3; mf = 1; end
                else if (a_stop) st = 0;
                else begin
                    cy++;
                    for (int i = 0; i < 4; i++) if (a_ev[i]) mc[i]++;
                end
            end else if (a_start) begin
                st = 1;
                cy = 0;
                mc = '{default: 0};
            end else if (st != 0 && a_stop) st = 0;
            for (int i = 0; i < 4; i++) exp_cnt[i*32 +: 32] = 32'(mc[i]);
            checks++; if (a_state !== 2'(st)) begin errors++; $display("FAIL rand_state n=%0d got=%0d exp=%0d", n, a_state, st); end
            checks++; if (a_cycles !== 32'(cy)) begin errors++; $display("FAIL rand_cycles n=%0d got=%0d exp=%0d", n, a_cycles, cy); end
            checks++; if (a_count !== exp_cnt) begin errors++; $display("FAIL rand_count n=%0d got=%0h exp=%0h", n, a_count, exp_cnt); end
            checks++; if ({a_done, a_timeout, a_fin} !== {st == 2, st == 3, mf}) begin errors++; $display("FAIL rand_flags n=%0d got=%b exp=%b", n, {a_done, a_timeout, a_fin}, {st == 2, st == 3, mf}); end
        end
        a_start = 0;
        a_stop = 0;
        a_ev = '0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_stop_restart();
        test_mid_reset();
        test_simultaneous();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
